// File: rtl/bfs_axi_pkg.sv
// rtl/bfs_axi_pkg.sv - shared AXI read constants and read FSM state type
package bfs_axi_pkg;

   localparam logic [2:0] AXI_SIZE_64B         = 3'b110;
   localparam logic [1:0] AXI_BURST_INCR       = 2'b01;
   localparam logic [3:0] AXI_CACHE_MODIFIABLE = 4'b0011;
   localparam logic [1:0] AXI_RESP_OKAY        = 2'b00;

   // 64-byte beats per 4 KB page
   localparam int BEATS_PER_4K = 64;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_ADDR,
      RD_DATA,
      RD_DONE
   } rd_state_t;

endpackage

// File: rtl/axi_burst_rd_master_if.sv
// rtl/axi_burst_rd_master_if.sv - AXI4 read address/data channel bundle
interface axi_burst_rd_master_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512
);
   logic              m_axi_arid;
   logic [ADDR_W-1:0] m_axi_araddr;
   logic [7:0]        m_axi_arlen;
   logic [2:0]        m_axi_arsize;
   logic [1:0]        m_axi_arburst;
   logic              m_axi_arlock;
   logic [3:0]        m_axi_arcache;
   logic [2:0]        m_axi_arprot;
   logic              m_axi_arvalid;
   logic              m_axi_arready;
   logic              m_axi_rid;
   logic [DATA_W-1:0] m_axi_rdata;
   logic [1:0]        m_axi_rresp;
   logic              m_axi_rlast;
   logic              m_axi_rvalid;
   logic              m_axi_rready;

   modport master (
      output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
      input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
             m_axi_rvalid
   );

   modport slave (
      input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
      output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
             m_axi_rvalid
   );

endinterface

// File: rtl/rd_burst_len_calc.sv
// rtl/rd_burst_len_calc.sv - burst length = min(remaining, MAX_BURST, beats to 4 KB edge)
module rd_burst_len_calc
   import bfs_axi_pkg::*;
#(
   parameter int MAX_BURST = 64
) (
   input  logic [31:0] i_remaining,
   input  logic [5:0]  i_addr_blk,
   output logic [8:0]  o_len
);

   localparam logic [8:0] C_MAX = 9'(MAX_BURST);

   logic [8:0] w_dist;
   logic [8:0] w_cap;

   // distance to the page edge is 1..64 beats, so the result is never zero
   // while remaining is non-zero
   always_comb begin
      w_dist = 9'(BEATS_PER_4K) - {3'b000, i_addr_blk};
      w_cap  = (C_MAX < w_dist) ? C_MAX : w_dist;
      o_len  = (i_remaining < {23'd0, w_cap}) ? i_remaining[8:0] : w_cap;
   end

endmodule

// File: rtl/axi_burst_rd_master.sv
// rtl/axi_burst_rd_master.sv - AXI4 read initiator splitting commands into 4 KB-safe INCR bursts
module axi_burst_rd_master
   import bfs_axi_pkg::*;
#(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 512,
   parameter int MAX_BURST = 64,
   parameter int AXI_ID    = 0
) (
   input  logic              m_axi_aclk,
   input  logic              m_axi_aresetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_beats,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              done,
   output logic              err,
   axi_burst_rd_master_if.master m_axi
);

   rd_state_t         r_state;
   rd_state_t         w_next;
   logic              r_live;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_remaining;
   logic [8:0]        r_beat_cnt;
   logic [8:0]        r_len;
   logic              r_err;

   logic [8:0]        w_len;
   logic              w_cmd_hs;
   logic              w_r_hs;
   logic              w_burst_end;
   logic              w_beat_bad;
   logic              w_unused;

   assign w_unused = ^{cmd_addr[5:0], m_axi.m_axi_rid};

   rd_burst_len_calc #(
      .MAX_BURST (MAX_BURST)
   ) u_len_calc (
      .i_remaining (r_remaining),
      .i_addr_blk  (r_addr[11:6]),
      .o_len       (w_len)
   );

   assign w_cmd_hs    = cmd_valid & cmd_ready;
   assign w_r_hs      = (r_state == RD_DATA) & m_axi.m_axi_rvalid & out_ready;
   assign w_burst_end = w_r_hs & (r_beat_cnt == 9'd1);
   assign w_beat_bad  = (m_axi.m_axi_rresp != AXI_RESP_OKAY) |
                        (m_axi.m_axi_rlast != (r_beat_cnt == 9'd1));

   assign m_axi.m_axi_arid    = 1'(AXI_ID);
   assign m_axi.m_axi_arsize  = AXI_SIZE_64B;
   assign m_axi.m_axi_arburst = AXI_BURST_INCR;
   assign m_axi.m_axi_arlock  = 1'b0;
   assign m_axi.m_axi_arcache = AXI_CACHE_MODIFIABLE;
   assign m_axi.m_axi_arprot  = 3'b000;
   assign out_data            = m_axi.m_axi_rdata;

   // state register; reset drops any in-flight burst
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         r_state <= RD_IDLE;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_live  <= 1'b1;
      end
   end

   // next state and all handshake outputs; AR fields come straight from held
   // registers so they stay stable until arready
   always_comb begin
      w_next               = r_state;
      cmd_ready            = 1'b0;
      out_valid            = 1'b0;
      out_last             = 1'b0;
      done                 = 1'b0;
      err                  = 1'b0;
      m_axi.m_axi_arvalid  = 1'b0;
      m_axi.m_axi_araddr   = '0;
      m_axi.m_axi_arlen    = 8'd0;
      m_axi.m_axi_rready   = 1'b0;
      unique case (r_state)
         RD_IDLE: begin
            cmd_ready = r_live;
            if (w_cmd_hs) begin
               w_next = (cmd_beats == 32'd0) ? RD_DONE : RD_ADDR;
            end
         end
         RD_ADDR: begin
            m_axi.m_axi_arvalid = 1'b1;
            m_axi.m_axi_araddr  = r_addr;
            m_axi.m_axi_arlen   = 8'(w_len - 9'd1);
            if (m_axi.m_axi_arready) begin
               w_next = RD_DATA;
            end
         end
         RD_DATA: begin
            m_axi.m_axi_rready = out_ready;
            out_valid          = m_axi.m_axi_rvalid;
            out_last           = m_axi.m_axi_rvalid & (r_beat_cnt == 9'd1) &
                                 (r_remaining == 32'd1);
            if (w_burst_end) begin
               w_next = (r_remaining == 32'd1) ? RD_DONE : RD_ADDR;
            end
         end
         RD_DONE: begin
            done   = 1'b1;
            err    = r_err;
            w_next = RD_IDLE;
         end
         default: w_next = RD_IDLE;
      endcase
   end

   // command latch, burst bookkeeping and sticky error flag
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         r_addr      <= '0;
         r_remaining <= 32'd0;
         r_beat_cnt  <= 9'd0;
         r_len       <= 9'd0;
         r_err       <= 1'b0;
      end else begin
         unique case (r_state)
            RD_IDLE: begin
               if (w_cmd_hs) begin
                  r_addr      <= {cmd_addr[ADDR_W-1:6], 6'b000000};
                  r_remaining <= cmd_beats;
                  r_err       <= 1'b0;
               end
            end
            RD_ADDR: begin
               if (m_axi.m_axi_arready) begin
                  r_beat_cnt <= w_len;
                  r_len      <= w_len;
               end
            end
            RD_DATA: begin
               if (w_r_hs) begin
                  r_beat_cnt  <= r_beat_cnt - 9'd1;
                  r_remaining <= r_remaining - 32'd1;
                  if (w_beat_bad) begin
                     r_err <= 1'b1;
                  end
                  if (r_beat_cnt == 9'd1) begin
                     r_addr <= r_addr + (ADDR_W'(r_len) << 6);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_burst_rd_master.sv
// tb/tb_axi_burst_rd_master.sv - scoreboard bench for axi_burst_rd_master
`timescale 1ns/1ps
module tb_axi_burst_rd_master;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 512;
   localparam int MAX_B  = 64;

   typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;
   typedef struct { logic [63:0] d; logic last; } beat_t;
   typedef struct { logic e; bit zero; } done_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [63:0]       cmd_addr = '0;
   logic [31:0]       cmd_beats = '0;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              done;
   logic              err;

   axi_burst_rd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

   axi_burst_rd_master #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_B), .AXI_ID(0)
   ) dut (
      .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_beats(cmd_beats), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .done(done), .err(err),
      .m_axi(axi)
   );

   int n_vec = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_done = 0;
   int n_beats = 0;
   int last_cyc = 0;

   ar_t   exp_ar[$];
   beat_t exp_beat[$];
   done_t exp_done[$];

   int  s_err_beat = -1;
   bit  rand_mode = 0;
   bit  rand_ar = 0;
   bit  hs_ar = 0, hs_r = 0, hs_cmd = 0;
   logic [63:0] cap_addr;
   logic [7:0]  cap_len;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // AXI slave: memory word at a beat address holds that beat address
   initial begin : slave
      logic [63:0] s_addr;
      int s_left;
      int s_beat_num;
      bit s_busy;
      s_addr = '0; s_left = 0; s_beat_num = 0; s_busy = 0;
      axi.m_axi_arready = 0; axi.m_axi_rvalid = 0; axi.m_axi_rdata = '0;
      axi.m_axi_rresp = 0; axi.m_axi_rlast = 0; axi.m_axi_rid = 0;
      out_ready = 0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            s_busy = 0; s_left = 0;
            axi.m_axi_arready = 0; axi.m_axi_rvalid = 0; axi.m_axi_rlast = 0;
            out_ready = 0;
         end else begin
            if (hs_cmd) s_beat_num = 0;
            if (hs_r) begin
               s_addr += 64; s_left--; s_beat_num++;
               if (s_left == 0) s_busy = 0;
            end
            if (hs_ar) begin
               s_busy = 1; s_addr = cap_addr; s_left = int'(cap_len) + 1;
            end
            axi.m_axi_arready = !s_busy && (rand_ar ? ($urandom_range(0, 1) == 1) : 1'b1);
            if (!s_busy) axi.m_axi_rvalid = 0;
            else if (!axi.m_axi_rvalid || hs_r)
               axi.m_axi_rvalid = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
            axi.m_axi_rdata = {448'd0, s_addr >> 6};
            axi.m_axi_rlast = (s_left == 1);
            axi.m_axi_rresp = (s_beat_num == s_err_beat) ? 2'b10 : 2'b00;
            out_ready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
         end
      end
   end

   // monitor: samples on the falling edge, pops the scoreboard on each handshake
   initial begin : monitor
      bit ar_wait, ar_next;
      logic [63:0] w_addr;
      logic [7:0]  w_len;
      ar_t a; beat_t b; done_t d;
      ar_wait = 0; ar_next = 0; w_addr = '0; w_len = '0;
      forever begin
         @(negedge clk);
         hs_ar = 0; hs_r = 0; hs_cmd = 0;
         if (!rst_n) begin
            ar_wait = 0; ar_next = 0;
         end else begin
            if (ar_wait) begin
               chk("ar_hold_valid", axi.m_axi_arvalid, 1);
               chk("ar_hold_addr", axi.m_axi_araddr, w_addr);
               chk("ar_hold_len", axi.m_axi_arlen, w_len);
            end
            if (ar_next) chk("b2b_arvalid", axi.m_axi_arvalid, 1);
            ar_wait = axi.m_axi_arvalid && !axi.m_axi_arready;
            ar_next = 0;
            w_addr = axi.m_axi_araddr; w_len = axi.m_axi_arlen;
            hs_cmd = cmd_valid && cmd_ready;
            if (axi.m_axi_arvalid && axi.m_axi_arready) begin
               hs_ar = 1; cap_addr = axi.m_axi_araddr; cap_len = axi.m_axi_arlen;
               if (exp_ar.size() == 0) chk("unexpected_ar", axi.m_axi_araddr, 64'hDEAD);
               else begin
                  a = exp_ar.pop_front();
                  chk("araddr", axi.m_axi_araddr, a.addr);
                  chk("arlen", axi.m_axi_arlen, a.len);
               end
            end
            if (out_valid) chk("rready_tracks", axi.m_axi_rready, out_ready);
            if (out_valid && out_ready) begin
               hs_r = 1; n_beats++;
               if (exp_beat.size() == 0) chk("unexpected_beat", out_data[63:0], 64'hDEAD);
               else begin
                  b = exp_beat.pop_front();
                  chk("out_data", out_data[63:0], b.d);
                  chk("out_last", out_last, b.last);
               end
               if (axi.m_axi_rlast && !out_last) ar_next = 1;
               if (out_last) last_cyc = cyc;
            end
            if (done) begin
               n_done++;
               if (exp_done.size() == 0) chk("unexpected_done", done, 0);
               else begin
                  d = exp_done.pop_front();
                  chk("err", err, d.e);
                  if (!d.zero) chk("done_latency", cyc, last_cyc + 1);
               end
            end
         end
      end
   end

   // pushes the expected bursts/beats/status, then presents and accepts the command
   task automatic issue_cmd(input logic [63:0] addr, input int beats, input int eb);
      logic [63:0] a;
      int rem, l, blk, to;
      a = addr & ~64'h3F; rem = beats;
      while (rem > 0) begin
         blk = int'((a >> 6) & 64'h3F);
         l = rem;
         if (l > MAX_B) l = MAX_B;
         if (l > 64 - blk) l = 64 - blk;
         exp_ar.push_back('{a, 8'(l - 1)});
         a += 64'(l) * 64;
         rem -= l;
      end
      for (int k = 0; k < beats; k++)
         exp_beat.push_back('{(addr >> 6) + 64'(k), (k == beats - 1)});
      exp_done.push_back('{(eb >= 0 && eb < beats), (beats == 0)});
      s_err_beat = eb;
      @(posedge clk); #1;
      cmd_addr = addr; cmd_beats = beats; cmd_valid = 1;
      to = 0;
      @(negedge clk);
      while (!cmd_ready && to < 100) begin @(negedge clk); to++; end
      chk("cmd_ready_idle", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 0;
      @(negedge clk);
      if (beats == 0) begin
         chk("zero_done", done, 1);
         chk("zero_no_ar", axi.m_axi_arvalid, 0);
      end else begin
         chk("busy_holdoff", cmd_ready, 0);
      end
   endtask

   task automatic wait_done(input int start);
      int to;
      to = 0;
      while (n_done == start && to < 20000) begin @(negedge clk); to++; end
      chk("done_timeout", (n_done != start), 1);
   endtask

   task automatic run_cmd(input logic [63:0] addr, input int beats, input int eb);
      int start;
      start = n_done;
      issue_cmd(addr, beats, eb);
      if (beats != 0) wait_done(start);
   endtask

   initial begin : stim
      int to;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_arvalid", axi.m_axi_arvalid, 0);
      chk("rst_rready", axi.m_axi_rready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_araddr", axi.m_axi_araddr, 0);
      chk("rst_arlen", axi.m_axi_arlen, 0);
      rst_n = 1;
      @(negedge clk); chk("rel_cmd_ready_pre", cmd_ready, 0);
      @(negedge clk); chk("rel_cmd_ready", cmd_ready, 1);

      run_cmd(64'h0, 16, -1);
      run_cmd(64'hFC0, 4, -1);
      rand_ar = 1;
      run_cmd(64'h0, 200, -1);
      rand_ar = 0;
      rand_mode = 1;
      run_cmd(64'h0, 100, -1);
      rand_mode = 0;
      run_cmd(64'h40000, 8, 2);
      run_cmd(64'h40000, 8, -1);
      run_cmd(64'h100, 0, -1);
      run_cmd(64'h2007, 5, -1);

      // reset in the middle of a data burst
      issue_cmd(64'h0, 16, -1);
      to = 0;
      while (n_beats < 2 + 16 + 4 + 200 + 100 + 8 + 8 + 5 + 3 && to < 1000) begin
         @(negedge clk); to++;
      end
      @(posedge clk); #2;
      rst_n = 0;
      #1;
      chk("midrst_arvalid", axi.m_axi_arvalid, 0);
      chk("midrst_rready", axi.m_axi_rready, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_cmd_ready", cmd_ready, 0);
      exp_ar.delete(); exp_beat.delete(); exp_done.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      @(negedge clk); chk("midrst_rel_pre", cmd_ready, 0);
      @(negedge clk); chk("midrst_rel_ready", cmd_ready, 1);
      run_cmd(64'h0, 16, -1);

      repeat (4) @(negedge clk);
      chk("ar_queue_empty", exp_ar.size(), 0);
      chk("beat_queue_empty", exp_beat.size(), 0);
      chk("done_queue_empty", exp_done.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
